// File: rtl/sig_arb_link.sv
// Multi-channel FIFO link with a round-robin arbiter feeding one registered output stage.
// Optional handshake counter on xfer_cnt is built only when SIG_ARB_LINK_STATS_EN is defined.
module sig_arb_link #(
  parameter int WIDTH  = 3,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic [WIDTH-1:0]          last_sig,
  output logic [NUM_CH-1:0]         fifo_full
`ifdef SIG_ARB_LINK_STATS_EN
  ,output logic [15:0]              xfer_cnt
`endif
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]          mem_q [NUM_CH][DEPTH];
  logic [NUM_CH-1:0][AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][AW:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]         full_s, nonempty_s, push_s, pop_s;
  logic [CW-1:0]             rr_ptr_q, rr_ptr_d, grant_s;
  logic                      found_s, load_s;
  logic                      out_valid_q, out_valid_d;
  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic [CW-1:0]             out_ch_q, out_ch_d;
  logic [WIDTH-1:0]          last_sig_q, last_sig_d;

  // First requester at or after ptr, wrapping modulo NUM_CH; MSB flags a hit.
  function automatic logic [CW:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [CW-1:0] ptr);
    logic          hit;
    logic [CW-1:0] sel;
    int            idx;
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!hit && req[CW'(idx)]) begin
        hit = 1'b1;
        sel = CW'(idx);
      end
    end
    return {hit, sel};
  endfunction

  // FIFO status, arbitration and per-channel push/pop decisions.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full_s[c]     = (cnt_q[c] == FULL_CNT);
      nonempty_s[c] = (cnt_q[c] != '0);
    end
    {found_s, grant_s} = rr_pick(nonempty_s, rr_ptr_q);
    load_s = found_s && (!out_valid_q || out_ready);
    push_s = in_valid & ~full_s;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_s[c] = load_s && (grant_s == CW'(c));
    end
  end

  // Pointer and occupancy next state; a push and pop together keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_s[c]) begin
        wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c];
      end
      if (pop_s[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      end else begin
        rd_ptr_d[c] = rd_ptr_q[c];
      end
      case ({push_s[c], pop_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  // Output stage, round-robin pointer and last-handshake capture.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[grant_s][rd_ptr_q[grant_s]];
      out_ch_d    = grant_s;
      rr_ptr_d    = (grant_s == CW'(NUM_CH-1)) ? '0 : grant_s + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (out_valid_q && out_ready) begin
      last_sig_d = out_data_q;
    end else begin
      last_sig_d = last_sig_q;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_s[c]) begin
        mem_q[c][wr_ptr_q[c]] <= in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_sig_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_sig_q  <= last_sig_d;
    end
  end

  assign in_ready  = ~full_s;
  assign fifo_full = full_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign last_sig  = last_sig_q;

`ifdef SIG_ARB_LINK_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Saturating handshake counter.
  always_comb begin
    if (out_valid_q && out_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_sig_arb_link.sv
// Directed self-checking bench for sig_arb_link (WIDTH=3, NUM_CH=2, DEPTH=4).
// Define SIG_ARB_LINK_STATS_EN to also exercise the xfer_cnt saturation test.
module tb_sig_arb_link;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic [0:0] out_ch;
  logic [2:0] last_sig;
  logic [1:0] fifo_full;
`ifdef SIG_ARB_LINK_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  sig_arb_link #(.WIDTH(3), .NUM_CH(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .last_sig  (last_sig),
    .fifo_full (fifo_full)
`ifdef SIG_ARB_LINK_STATS_EN
    ,.xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_data   = 6'd0;
    out_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  logic [2:0] ch0_w [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [2:0] ch1_w [4] = '{3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] ord_w [8] = '{3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7, 3'd4, 3'd0};
  logic       rdy_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [2:0] dat_v [4] = '{3'd1, 3'd2, 3'd2, 3'd2};
  logic [2:0] lst_v [4] = '{3'd0, 3'd1, 3'd1, 3'd1};

  initial begin
    int  got;
    logic accepted;

    rst_n     = 1'b1;
    in_valid  = 2'b00;
    in_data   = 6'd0;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd3);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_last_sig",  32'(last_sig),  32'd0);
    tick;
    tick;
    rst_n = 1'b1;

    // single word latency
    in_valid  = 2'b01;
    in_data   = {3'd0, 3'd5};
    out_ready = 1'b1;
    tick;
    in_valid = 2'b00;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    tick;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data",  32'(out_data),  32'd5);
    chk("lat_ch",    32'(out_ch),    32'd0);
    tick;
    chk("lat_last",   32'(last_sig),  32'd5);
    chk("lat_idle",   32'(out_valid), 32'd0);
`ifdef SIG_ARB_LINK_STATS_EN
    chk("lat_xfer", 32'(xfer_cnt), 32'd1);
`endif

    // round-robin interleave
    do_reset;
    for (int i = 0; i < 4; i++) begin
      in_valid = 2'b11;
      in_data  = {ch1_w[i], ch0_w[i]};
      tick;
    end
    in_valid = 2'b00;
    chk("rr_full",     32'(fifo_full), 32'd2);
    chk("rr_in_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_data",  32'(out_data),  32'(ord_w[i]));
      chk("rr_ch",    32'(out_ch),    32'(i % 2));
      tick;
    end
    chk("rr_drained", 32'(out_valid), 32'd0);
    chk("rr_last",    32'(last_sig),  32'd0);

    // backpressure and full FIFO on ch1
    do_reset;
    for (int w = 1; w <= 5; w++) begin
      in_valid = 2'b10;
      in_data  = {3'(w), 3'd0};
      tick;
    end
    chk("bp_full",     32'(fifo_full), 32'd2);
    chk("bp_in_ready", 32'(in_ready),  32'd1);
    in_data = {3'd6, 3'd0};
    tick;
    chk("bp_held_ready", 32'(in_ready), 32'd1);
    chk("bp_held_data",  32'(out_data), 32'd1);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
      accepted = in_valid[1] && in_ready[1];
      if (out_valid && out_ready) begin
        chk("bp_drain", 32'(out_data), 32'(got + 1));
        got++;
      end
      tick;
      if (accepted) in_valid = 2'b00;
    end
    chk("bp_count",      32'(got),       32'd6);
    chk("bp_empty_full", 32'(fifo_full), 32'd0);

    // stall stability with out_ready 1,0,0,1
    do_reset;
    for (int w = 1; w <= 3; w++) begin
      in_valid = 2'b10;
      in_data  = {3'(w), 3'd0};
      tick;
    end
    in_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy_v[i];
      chk("stall_data", 32'(out_data), 32'(dat_v[i]));
      chk("stall_ch",   32'(out_ch),   32'd1);
      chk("stall_last", 32'(last_sig), 32'(lst_v[i]));
      tick;
    end
    chk("stall_next_data", 32'(out_data), 32'd3);
    chk("stall_next_last", 32'(last_sig), 32'd2);

    // reset mid-burst with buffered words
    out_ready = 1'b0;
    for (int w = 4; w <= 6; w++) begin
      in_valid = 2'b01;
      in_data  = {3'd0, 3'(w)};
      tick;
    end
    in_valid = 2'b00;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_last",  32'(last_sig),  32'd0);
    chk("mid_full",  32'(fifo_full), 32'd0);
    chk("mid_ready", 32'(in_ready),  32'd3);
    chk("mid_data",  32'(out_data),  32'd0);
    tick;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    in_valid = 2'b11;
    in_data  = {3'd4, 3'd2};
    tick;
    in_valid = 2'b00;
    tick;
    chk("resume_data0", 32'(out_data), 32'd2);
    chk("resume_ch0",   32'(out_ch),   32'd0);
    tick;
    chk("resume_data1", 32'(out_data), 32'd4);
    chk("resume_ch1",   32'(out_ch),   32'd1);
    tick;
    chk("resume_idle", 32'(out_valid), 32'd0);

`ifdef SIG_ARB_LINK_STATS_EN
    // counter saturation
    do_reset;
    out_ready = 1'b1;
    in_valid  = 2'b01;
    in_data   = {3'd0, 3'd3};
    for (int i = 0; i < 70005; i++) tick;
    in_valid = 2'b00;
    chk("xfer_sat", 32'(xfer_cnt), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
